// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: issue-gating ring, load-use and HI/LO
// interlocks, branch flush. Define HAZARD_STATS_EN to add stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned ISSUE_PERIOD = 1,
  parameter int unsigned MD_LATENCY   = 4,
  parameter int unsigned REG_AW       = 5
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [REG_AW-1:0]       ID_RS,
  input  logic [REG_AW-1:0]       ID_RT,
  input  logic                    ID_USES_RS,
  input  logic                    ID_USES_RT,
  input  logic                    ID_READS_HILO,
  input  logic                    EXE_MEMREAD,
  input  logic [REG_AW-1:0]       EXE_RD,
  input  logic                    BRANCH_TAKEN,
  input  logic                    MD_START,
  output logic                    STALL_IFID,
  output logic                    FLUSH_IFID,
  output logic                    STALL_IDEXE,
  output logic                    FLUSH_IDEXE,
  output logic                    STALL_EXEMEM,
  output logic                    FLUSH_EXEMEM,
  output logic                    STALL_MEMWB,
  output logic                    FLUSH_MEMWB,
  output logic [ISSUE_PERIOD-1:0] RING_STATE,
`ifdef HAZARD_STATS_EN
  output logic                    MD_BUSY,
  output logic [31:0]             STALL_CNT,
  output logic [31:0]             FLUSH_CNT
`else
  output logic                    MD_BUSY
`endif
);

  localparam int unsigned MdW = $clog2(MD_LATENCY + 1);
  localparam logic [ISSUE_PERIOD-1:0] RingReset = ISSUE_PERIOD'(1);
  localparam logic [MdW-1:0] MdLoad = MdW'(MD_LATENCY);

  logic [ISSUE_PERIOD-1:0] ring_q, ring_d;
  logic [MdW-1:0]          md_q, md_d;
  logic                    lu, hl, hazard;

  always_comb begin
    lu = EXE_MEMREAD && (EXE_RD != '0) &&
         ((ID_USES_RS && (ID_RS == EXE_RD)) || (ID_USES_RT && (ID_RT == EXE_RD)));
    hl = ID_READS_HILO && ((md_q != '0) || MD_START);
    hazard = lu || hl;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ring_q <= RingReset;
      md_q   <= '0;
    end else begin
      ring_q <= ring_d;
      md_q   <= md_d;
    end
  end

  always_comb begin
    ring_d = ring_q;
    // A hazard cycle freezes the ring so the pending issue slot is not lost.
    if (!hazard) begin
      ring_d = (ring_q << 1) | (ring_q >> (ISSUE_PERIOD - 1));
    end
    md_d = md_q;
    if (MD_START) begin
      md_d = MdLoad;
    end else if (md_q != '0) begin
      md_d = md_q - MdW'(1);
    end
  end

  always_comb begin
    STALL_IFID   = hazard || !ring_q[0];
    FLUSH_IFID   = !hazard && (!ring_q[0] || BRANCH_TAKEN);
    STALL_IDEXE  = 1'b0;
    FLUSH_IDEXE  = hazard;
    STALL_EXEMEM = 1'b0;
    FLUSH_EXEMEM = 1'b0;
    STALL_MEMWB  = 1'b0;
    FLUSH_MEMWB  = 1'b0;
    RING_STATE   = ring_q;
    MD_BUSY      = (md_q != '0);
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (FLUSH_IFID) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one full-throughput instance and one with a 3-cycle
// issue ring, driven from shared inputs.
module tb_hazard_ctrl;

  logic       CLOCK, RESET;
  logic [4:0] id_rs, id_rt, exe_rd;
  logic       uses_rs, uses_rt, reads_hilo, exe_memread, branch_taken, md_start;

  logic       s_ifid1, f_ifid1, s_idexe1, f_idexe1, s_em1, f_em1, s_mw1, f_mw1, busy1;
  logic [0:0] ring1;
  logic       s_ifid3, f_ifid3, s_idexe3, f_idexe3, s_em3, f_em3, s_mw3, f_mw3, busy3;
  logic [2:0] ring3;
`ifdef HAZARD_STATS_EN
  logic [31:0] scnt1, fcnt1, scnt3, fcnt3;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.ISSUE_PERIOD(1), .MD_LATENCY(4), .REG_AW(5)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(uses_rs),
    .ID_USES_RT(uses_rt), .ID_READS_HILO(reads_hilo), .EXE_MEMREAD(exe_memread),
    .EXE_RD(exe_rd), .BRANCH_TAKEN(branch_taken), .MD_START(md_start),
    .STALL_IFID(s_ifid1), .FLUSH_IFID(f_ifid1), .STALL_IDEXE(s_idexe1),
    .FLUSH_IDEXE(f_idexe1), .STALL_EXEMEM(s_em1), .FLUSH_EXEMEM(f_em1),
    .STALL_MEMWB(s_mw1), .FLUSH_MEMWB(f_mw1), .RING_STATE(ring1),
`ifdef HAZARD_STATS_EN
    .STALL_CNT(scnt1), .FLUSH_CNT(fcnt1),
`endif
    .MD_BUSY(busy1)
  );

  hazard_ctrl #(.ISSUE_PERIOD(3), .MD_LATENCY(4), .REG_AW(5)) dut3 (
    .CLOCK(CLOCK), .RESET(RESET), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(uses_rs),
    .ID_USES_RT(uses_rt), .ID_READS_HILO(reads_hilo), .EXE_MEMREAD(exe_memread),
    .EXE_RD(exe_rd), .BRANCH_TAKEN(branch_taken), .MD_START(md_start),
    .STALL_IFID(s_ifid3), .FLUSH_IFID(f_ifid3), .STALL_IDEXE(s_idexe3),
    .FLUSH_IDEXE(f_idexe3), .STALL_EXEMEM(s_em3), .FLUSH_EXEMEM(f_em3),
    .STALL_MEMWB(s_mw3), .FLUSH_MEMWB(f_mw3), .RING_STATE(ring3),
`ifdef HAZARD_STATS_EN
    .STALL_CNT(scnt3), .FLUSH_CNT(fcnt3),
`endif
    .MD_BUSY(busy3)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       mr;
    logic [4:0] rd, rs, rt;
    logic       urs, urt, hilo, mds, br;
    logic       e_stall, e_fifid, e_fidexe, e_busy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                              input logic [4:0] rt, input logic urs, input logic urt,
                              input logic hilo, input logic mds, input logic br,
                              input logic es, input logic ef, input logic ex, input logic eb);
    vec_t v;
    v.mr = mr; v.rd = rd; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.hilo = hilo; v.mds = mds; v.br = br;
    v.e_stall = es; v.e_fifid = ef; v.e_fidexe = ex; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    id_rs = '0; id_rt = '0; exe_rd = '0; uses_rs = 0; uses_rt = 0; reads_hilo = 0;
    exe_memread = 0; branch_taken = 0; md_start = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " dut others"}, {31'd0, s_idexe1 | s_em1 | f_em1 | s_mw1 | f_mw1}, 32'd0);
    chk({tag, " dut3 others"}, {31'd0, s_idexe3 | s_em3 | f_em3 | s_mw3 | f_mw3}, 32'd0);
  endtask

  initial begin
    // mr rd rs rt urs urt hilo mds br | stall fifid fidexe busy
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 8, 8, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 9, 0, 9, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    vecs[5]  = mk(1, 9, 3, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 9, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    vecs[8]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    RESET = 1'b0;
    zero_inputs();
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    chk("reset ctl1", {28'd0, s_ifid1, f_ifid1, f_idexe1, busy1}, 32'd0);
    chk("reset ctl3", {28'd0, s_ifid3, f_ifid3, f_idexe3, busy3}, 32'd0);
    chk("reset ring1", {31'd0, ring1}, 32'd1);
    chk("reset ring3", {29'd0, ring3}, 32'd1);
    check_quiet("reset");

    foreach (vecs[i]) begin
      @(posedge CLOCK); #1;
      exe_memread = vecs[i].mr; exe_rd = vecs[i].rd; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      uses_rs = vecs[i].urs; uses_rt = vecs[i].urt; reads_hilo = vecs[i].hilo;
      md_start = vecs[i].mds; branch_taken = vecs[i].br;
      @(negedge CLOCK);
      chk($sformatf("vec%0d stall", i), {31'd0, s_ifid1}, {31'd0, vecs[i].e_stall});
      chk($sformatf("vec%0d fifid", i), {31'd0, f_ifid1}, {31'd0, vecs[i].e_fifid});
      chk($sformatf("vec%0d fidexe", i), {31'd0, f_idexe1}, {31'd0, vecs[i].e_fidexe});
      chk($sformatf("vec%0d busy", i), {31'd0, busy1}, {31'd0, vecs[i].e_busy});
      chk($sformatf("vec%0d ring1", i), {31'd0, ring1}, 32'd1);
      check_quiet($sformatf("vec%0d", i));
    end

    // HI/LO window: MD_START at cycle 0, MFHI held in ID.
    for (int c = 0; c <= 5; c++) begin
      @(posedge CLOCK); #1;
      zero_inputs();
      reads_hilo = 1;
      md_start = (c == 0);
      @(negedge CLOCK);
      chk($sformatf("hilo c%0d fidexe", c), {31'd0, f_idexe1}, {31'd0, c <= 4});
      chk($sformatf("hilo c%0d busy", c), {31'd0, busy1}, {31'd0, (c >= 1) && (c <= 4)});
    end

    // Restart while busy extends the window.
    for (int c = 0; c <= 7; c++) begin
      @(posedge CLOCK); #1;
      zero_inputs();
      md_start = (c == 0) || (c == 2);
      @(negedge CLOCK);
      chk($sformatf("restart c%0d busy", c), {31'd0, busy1}, {31'd0, (c >= 1) && (c <= 6)});
    end

    // Issue ring of period 3 from reset release.
    @(posedge CLOCK); #1;
    zero_inputs();
    RESET = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    chk("ring c0 stall", {31'd0, s_ifid3}, 32'd0);
    chk("ring c0 flush", {31'd0, f_ifid3}, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLOCK);
      chk($sformatf("ring c%0d stall", c), {31'd0, s_ifid3}, {31'd0, (c % 3) != 0});
      chk($sformatf("ring c%0d flush", c), {31'd0, f_ifid3}, {31'd0, (c % 3) != 0});
    end

    // Load-use on an open slot: ring holds, slot reopens once hazard clears.
    @(posedge CLOCK); #1;
    exe_memread = 1; exe_rd = 5'd8; uses_rs = 1; id_rs = 5'd8;
    @(negedge CLOCK);
    chk("lu slot stall", {31'd0, s_ifid3}, 32'd1);
    chk("lu slot flush", {31'd0, f_ifid3}, 32'd0);
    chk("lu slot ring", {29'd0, ring3}, 32'd1);
    @(posedge CLOCK); #1;
    zero_inputs();
    @(negedge CLOCK);
    chk("slot reopen stall", {31'd0, s_ifid3}, 32'd0);
    chk("slot reopen ring", {29'd0, ring3}, 32'd1);
    @(negedge CLOCK);
    chk("after slot stall", {31'd0, s_ifid3}, 32'd1);
    chk("after slot ring", {29'd0, ring3}, 32'd2);

    // Closed slot plus branch: both stall and flush; also start a mult/div.
    @(posedge CLOCK); #1;
    branch_taken = 1; md_start = 1;
    @(negedge CLOCK);
    chk("closed+br stall", {31'd0, s_ifid3}, 32'd1);
    chk("closed+br flush", {31'd0, f_ifid3}, 32'd1);
    @(posedge CLOCK); #1;
    zero_inputs();
    @(negedge CLOCK);
    chk("md loaded busy", {31'd0, busy3}, 32'd1);
    chk("md loaded ring", {29'd0, ring3}, 32'd1);

    // Asynchronous reset mid-cycle with md_count=3 and ring at bit 1.
    @(posedge CLOCK); #2;
    chk("pre-rst busy", {31'd0, busy3}, 32'd1);
    chk("pre-rst ring", {29'd0, ring3}, 32'd2);
`ifdef HAZARD_STATS_EN
    chk("pre-rst stall_cnt", scnt3, 32'd1);
    chk("pre-rst flush_cnt", fcnt3, 32'd6);
`endif
    RESET = 1'b0;
    #1;
    chk("async rst busy3", {31'd0, busy3}, 32'd0);
    chk("async rst busy1", {31'd0, busy1}, 32'd0);
    chk("async rst ring3", {29'd0, ring3}, 32'd1);
    chk("async rst stall3", {31'd0, s_ifid3}, 32'd0);
`ifdef HAZARD_STATS_EN
    chk("async rst stall_cnt", scnt3, 32'd0);
    chk("async rst flush_cnt", fcnt3, 32'd0);
    chk("async rst cnt1", scnt1 | fcnt1, 32'd0);
`endif
    @(negedge CLOCK);
    RESET = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
